// File: rtl/dino_collision_score.sv
// Dino hitbox collision against two obstacles, IDLE/RUN/OVER game FSM,
// 4-digit BCD score with high score, and obstacle-generator run enable.
module dino_collision_score #(
   parameter int unsigned DINO_X_MIN = 20,
   parameter int unsigned DINO_X_MAX = 35,
   parameter int unsigned SCORE_DIV  = 8,
   parameter int unsigned OVER_HOLD  = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [8:0]  obstacle1_pos,
   input  logic [8:0]  obstacle2_pos,
   input  logic [2:0]  obstacle1_type,
   input  logic [2:0]  obstacle2_type,
   input  logic [5:0]  dino_y,
   input  logic        dino_duck,
   input  logic        start_btn,
   output logic [1:0]  game_state,
   output logic        obst_rst_n,
   output logic        collision,
   output logic [15:0] score,
   output logic [15:0] hi_score
);

   localparam int unsigned EXT_W  = 10;
   localparam int unsigned PRE_W  = (SCORE_DIV > 1) ? $clog2(SCORE_DIV) : 1;
   localparam int unsigned HOLD_W = $clog2(OVER_HOLD + 1);
   localparam logic [15:0] SCORE_MAX = 16'h9999;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_OVER = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic                hit_q, start_q, coll_q, coll_d, obst_q, obst_d;
   logic [PRE_W-1:0]    pre_q, pre_d;
   logic [HOLD_W-1:0]   hold_q, hold_d;
   logic [15:0]         score_q, score_d, hi_q, hi_d;
   logic                hit_comb, start_rise;

   // One obstacle against the hitbox; pos+width is formed in 10 bits so it cannot wrap.
   function automatic logic obst_hit(input logic [8:0] pos, input logic [2:0] typ,
                                     input logic [5:0] y, input logic duck);
      logic [EXT_W-1:0] w;
      logic [EXT_W-1:0] right;
      logic [5:0]       h;
      logic             overlap;
      logic             vert;
      w       = typ[2] ? EXT_W'(12) : EXT_W'(8);
      right   = {1'b0, pos} + w - EXT_W'(1);
      overlap = (pos != 9'd0) && ({1'b0, pos} <= EXT_W'(DINO_X_MAX)) &&
                (right >= EXT_W'(DINO_X_MIN));
      h       = 6'd10 + {2'b00, typ[1:0], 2'b00};
      if (!typ[2])
         vert = (y < h);
      else if (!typ[1])
         vert = (y < 6'd16);
      else
         vert = !duck && (y < 6'd24);
      return overlap && vert;
   endfunction

   function automatic logic [15:0] bcd_inc(input logic [15:0] v);
      logic [15:0] r;
      logic        carry;
      r     = v;
      carry = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (carry) begin
            if (r[4*i +: 4] == 4'd9) begin
               r[4*i +: 4] = 4'd0;
            end else begin
               r[4*i +: 4] = r[4*i +: 4] + 4'd1;
               carry       = 1'b0;
            end
         end
      end
      return r;
   endfunction

   assign hit_comb   = obst_hit(obstacle1_pos, obstacle1_type, dino_y, dino_duck) |
                       obst_hit(obstacle2_pos, obstacle2_type, dino_y, dino_duck);
   assign start_rise = start_btn & ~start_q;

   // Next state, score/prescaler/hold updates and registered output values.
   always_comb begin
      state_d = state_q;
      pre_d   = pre_q;
      hold_d  = hold_q;
      score_d = score_q;
      hi_d    = hi_q;
      coll_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start_rise) begin
               state_d = S_RUN;
               score_d = '0;
               pre_d   = '0;
            end
         end
         S_RUN: begin
            if (hit_q) begin
               // Increment is suppressed here so the frozen score is pre-collision.
               state_d = S_OVER;
               coll_d  = 1'b1;
               hold_d  = '0;
               if (score_q > hi_q)
                  hi_d = score_q;
            end else if (pre_q == PRE_W'(SCORE_DIV - 1)) begin
               pre_d = '0;
               if (score_q != SCORE_MAX)
                  score_d = bcd_inc(score_q);
            end else begin
               pre_d = pre_q + PRE_W'(1);
            end
         end
         S_OVER: begin
            if (hold_q != HOLD_W'(OVER_HOLD)) begin
               hold_d = hold_q + HOLD_W'(1);
            end else if (start_rise) begin
               state_d = S_RUN;
               score_d = '0;
               pre_d   = '0;
            end
         end
         default: state_d = S_IDLE;
      endcase
      obst_d = (state_d == S_RUN);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         hit_q   <= 1'b0;
         start_q <= 1'b0;
         pre_q   <= '0;
         hold_q  <= '0;
         score_q <= '0;
         hi_q    <= '0;
         coll_q  <= 1'b0;
         obst_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         hit_q   <= hit_comb;
         start_q <= start_btn;
         pre_q   <= pre_d;
         hold_q  <= hold_d;
         score_q <= score_d;
         hi_q    <= hi_d;
         coll_q  <= coll_d;
         obst_q  <= obst_d;
      end
   end

   assign game_state = state_q;
   assign obst_rst_n = obst_q;
   assign collision  = coll_q;
   assign score      = score_q;
   assign hi_score   = hi_q;

endmodule

// File: tb/tb_dino_collision_score.sv
// Directed bench for dino_collision_score: geometry vector table plus
// hand sequences for game flow, hold time, saturation and async reset.
module tb_dino_collision_score;

   logic        clk = 1'b0;
   logic        rst_n, rst_n_f;
   logic [8:0]  p1, p2;
   logic [2:0]  t1, t2;
   logic [5:0]  y;
   logic        duck, start;
   logic [1:0]  gs, gs_f;
   logic        orn, orn_f, col, col_f;
   logic [15:0] sc, sc_f, hi, hi_f;

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      logic [8:0] p1;
      logic [2:0] t1;
      logic [8:0] p2;
      logic [2:0] t2;
      logic [5:0] y;
      logic       duck;
      logic       hit;
   } vec_t;

   vec_t vecs[$];

   always #5 clk = ~clk;

   dino_collision_score u_dut (
      .clk(clk), .rst_n(rst_n),
      .obstacle1_pos(p1), .obstacle2_pos(p2),
      .obstacle1_type(t1), .obstacle2_type(t2),
      .dino_y(y), .dino_duck(duck), .start_btn(start),
      .game_state(gs), .obst_rst_n(orn), .collision(col),
      .score(sc), .hi_score(hi)
   );

   dino_collision_score #(.SCORE_DIV(1)) u_fast (
      .clk(clk), .rst_n(rst_n_f),
      .obstacle1_pos(p1), .obstacle2_pos(p2),
      .obstacle1_type(t1), .obstacle2_type(t2),
      .dino_y(y), .dino_duck(duck), .start_btn(start),
      .game_state(gs_f), .obst_rst_n(orn_f), .collision(col_f),
      .score(sc_f), .hi_score(hi_f)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic set_obst(input logic [8:0] a, input logic [2:0] ta, input logic [8:0] b,
                           input logic [2:0] tb, input logic [5:0] yy, input logic dd);
      p1 = a; t1 = ta; p2 = b; t2 = tb; y = yy; duck = dd;
   endtask

   function automatic vec_t mk(input logic [8:0] a, input logic [2:0] ta, input logic [8:0] b,
                               input logic [2:0] tb, input logic [5:0] yy, input logic dd,
                               input logic h);
      vec_t v;
      v.p1 = a; v.t1 = ta; v.p2 = b; v.t2 = tb; v.y = yy; v.duck = dd; v.hit = h;
      return v;
   endfunction

   // Wait out the OVER hold, then restart.
   task automatic restart(input string name);
      ticks(20);
      start = 1'b1;
      tick();
      check({name, "_restart"}, 32'(gs), 32'd1);
      start = 1'b0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; rst_n_f = 1'b0; start = 1'b0;
      set_obst(9'd0, 3'd0, 9'd0, 3'd0, 6'd0, 1'b0);

      vecs.push_back(mk(9'd30,  3'd2, 9'd0,  3'd0, 6'd5,  1'b0, 1'b1));
      vecs.push_back(mk(9'd30,  3'd2, 9'd0,  3'd0, 6'd18, 1'b0, 1'b0));
      vecs.push_back(mk(9'd30,  3'd2, 9'd0,  3'd0, 6'd17, 1'b0, 1'b1));
      vecs.push_back(mk(9'd30,  3'd6, 9'd0,  3'd0, 6'd0,  1'b1, 1'b0));
      vecs.push_back(mk(9'd30,  3'd6, 9'd0,  3'd0, 6'd0,  1'b0, 1'b1));
      vecs.push_back(mk(9'd30,  3'd7, 9'd0,  3'd0, 6'd23, 1'b0, 1'b1));
      vecs.push_back(mk(9'd30,  3'd7, 9'd0,  3'd0, 6'd24, 1'b0, 1'b0));
      vecs.push_back(mk(9'd30,  3'd4, 9'd0,  3'd0, 6'd15, 1'b1, 1'b1));
      vecs.push_back(mk(9'd30,  3'd5, 9'd0,  3'd0, 6'd16, 1'b0, 1'b0));
      vecs.push_back(mk(9'd36,  3'd0, 9'd0,  3'd0, 6'd0,  1'b0, 1'b0));
      vecs.push_back(mk(9'd35,  3'd0, 9'd0,  3'd0, 6'd0,  1'b0, 1'b1));
      vecs.push_back(mk(9'd13,  3'd0, 9'd0,  3'd0, 6'd0,  1'b0, 1'b1));
      vecs.push_back(mk(9'd12,  3'd0, 9'd0,  3'd0, 6'd0,  1'b0, 1'b0));
      vecs.push_back(mk(9'd0,   3'd4, 9'd0,  3'd6, 6'd0,  1'b0, 1'b0));
      vecs.push_back(mk(9'd9,   3'd4, 9'd0,  3'd0, 6'd0,  1'b0, 1'b1));
      vecs.push_back(mk(9'd8,   3'd4, 9'd0,  3'd0, 6'd0,  1'b0, 1'b0));
      vecs.push_back(mk(9'd30,  3'd3, 9'd0,  3'd0, 6'd21, 1'b0, 1'b1));
      vecs.push_back(mk(9'd30,  3'd3, 9'd0,  3'd0, 6'd22, 1'b0, 1'b0));
      vecs.push_back(mk(9'd511, 3'd0, 9'd0,  3'd0, 6'd0,  1'b0, 1'b0));
      vecs.push_back(mk(9'd0,   3'd0, 9'd20, 3'd1, 6'd13, 1'b0, 1'b1));
      vecs.push_back(mk(9'd0,   3'd0, 9'd20, 3'd1, 6'd14, 1'b0, 1'b0));
      vecs.push_back(mk(9'd25,  3'd0, 9'd30, 3'd6, 6'd0,  1'b0, 1'b1));
      vecs.push_back(mk(9'd36,  3'd0, 9'd12, 3'd0, 6'd0,  1'b0, 1'b0));
      vecs.push_back(mk(9'd506, 3'd4, 9'd0,  3'd0, 6'd0,  1'b0, 1'b0));

      @(negedge clk);
      check("rst_state", 32'(gs), 32'd0);
      check("rst_obst",  32'(orn), 32'd0);
      check("rst_coll",  32'(col), 32'd0);
      check("rst_score", 32'(sc), 32'd0);
      check("rst_hi",    32'(hi), 32'd0);
      rst_n = 1'b1;
      tick();
      check("idle_hold", 32'(gs), 32'd0);

      // Start and free-run 80 clocks with no obstacles.
      start = 1'b1;
      tick();
      check("start_state", 32'(gs), 32'd1);
      check("start_obst",  32'(orn), 32'd1);
      check("start_score", 32'(sc), 32'd0);
      start = 1'b0;
      for (int i = 0; i < 80; i++) begin
         tick();
         check("run_no_coll", 32'(col), 32'd0);
      end
      check("run80_score", 32'(sc), 32'h0010);
      check("run80_state", 32'(gs), 32'd1);

      // First collision: two clocks of latency, one-clock pulse.
      set_obst(9'd30, 3'd2, 9'd0, 3'd0, 6'd5, 1'b0);
      tick();
      check("hit_lat_state", 32'(gs), 32'd1);
      set_obst(9'd0, 3'd0, 9'd0, 3'd0, 6'd0, 1'b0);
      tick();
      check("hit_state", 32'(gs), 32'd2);
      check("hit_coll",  32'(col), 32'd1);
      check("hit_obst",  32'(orn), 32'd0);
      check("hit_score", 32'(sc), 32'h0010);
      check("hit_hi",    32'(hi), 32'h0010);
      tick();
      check("coll_pulse", 32'(col), 32'd0);

      // Early press at hold 5 is dropped; held button is not queued.
      ticks(4);
      start = 1'b1;
      tick();
      check("early_press", 32'(gs), 32'd2);
      ticks(20);
      check("held_no_queue", 32'(gs), 32'd2);
      start = 1'b0;
      tick();
      start = 1'b1;
      tick();
      check("restart_state", 32'(gs), 32'd1);
      check("restart_score", 32'(sc), 32'h0000);
      check("restart_hi",    32'(hi), 32'h0010);
      check("restart_obst",  32'(orn), 32'd1);
      start = 1'b0;

      // Start ignored in RUN; lower-score collision on a prescaler wrap edge.
      ticks(20);
      start = 1'b1;
      tick();
      check("start_in_run", 32'(gs), 32'd1);
      check("start_in_run_score", 32'(sc), 32'h0002);
      start = 1'b0;
      tick();
      set_obst(9'd30, 3'd2, 9'd0, 3'd0, 6'd5, 1'b0);
      tick();
      set_obst(9'd0, 3'd0, 9'd0, 3'd0, 6'd0, 1'b0);
      tick();
      check("low_state", 32'(gs), 32'd2);
      check("low_score_frozen", 32'(sc), 32'h0002);
      check("low_hi_kept", 32'(hi), 32'h0010);
      restart("low");

      // Geometry table.
      foreach (vecs[i]) begin
         set_obst(vecs[i].p1, vecs[i].t1, vecs[i].p2, vecs[i].t2, vecs[i].y, vecs[i].duck);
         tick();
         set_obst(9'd0, 3'd0, 9'd0, 3'd0, 6'd0, 1'b0);
         tick();
         check($sformatf("vec%0d_state", i), 32'(gs), vecs[i].hit ? 32'd2 : 32'd1);
         check($sformatf("vec%0d_coll", i), 32'(col), 32'(vecs[i].hit));
         if (vecs[i].hit) begin
            check($sformatf("vec%0d_hi", i), 32'(hi), 32'h0010);
            tick();
            check($sformatf("vec%0d_pulse", i), 32'(col), 32'd0);
            restart($sformatf("vec%0d", i));
         end
      end

      // Async reset mid-RUN, away from any clock edge.
      check("pre_rst_state", 32'(gs), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("arst_state", 32'(gs), 32'd0);
      check("arst_obst",  32'(orn), 32'd0);
      check("arst_coll",  32'(col), 32'd0);
      check("arst_score", 32'(sc), 32'd0);
      check("arst_hi",    32'(hi), 32'd0);

      // Long run with SCORE_DIV=1: BCD carries and saturation.
      @(negedge clk);
      rst_n_f = 1'b1;
      tick();
      start = 1'b1;
      tick();
      check("fast_start", 32'(gs_f), 32'd1);
      start = 1'b0;
      ticks(1234);
      check("fast_1234", 32'(sc_f), 32'h1234);
      ticks(8765);
      check("fast_9999", 32'(sc_f), 32'h9999);
      ticks(50);
      check("fast_sat", 32'(sc_f), 32'h9999);
      check("fast_state", 32'(gs_f), 32'd1);
      check("fast_obst", 32'(orn_f), 32'd1);
      #2 rst_n_f = 1'b0;
      #1;
      check("fast_arst_state", 32'(gs_f), 32'd0);
      check("fast_arst_score", 32'(sc_f), 32'd0);
      check("fast_arst_obst",  32'(orn_f), 32'd0);
      check("fast_arst_coll",  32'(col_f), 32'd0);
      check("fast_arst_hi",    32'(hi_f), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/dino_collision_score.md
Name: dino_collision_score

Overview:
- Downstream consumer of the obstacle generator.
- Each clock it compares the two obstacle position/type pairs against the dino hitbox (x window plus vertical height/duck state) and runs the game state machine (IDLE/RUN/OVER).
- Keeps a 4-digit BCD score and a high score.
- Drives a synchronous-reset enable back to the obstacle generator, so obstacles only move while the game runs.

Parameters:
- DINO_X_MIN, 20, leftmost screen column of the dino hitbox.
- DINO_X_MAX, 35, rightmost screen column of the dino hitbox (inclusive).
- SCORE_DIV, 8, clocks per score increment while running (>=1).
- OVER_HOLD, 16, minimum clocks spent in OVER before a restart is accepted.

Ports:
- clk  input  1  system clock; one clock equals one obstacle step.
- rst_n  input  1  asynchronous active-low reset.
- obstacle1_pos  input  9  obstacle 1 x position; 0 = inactive.
- obstacle2_pos  input  9  obstacle 2 x position; 0 = inactive.
- obstacle1_type  input  3  obstacle 1 type.
- obstacle2_type  input  3  obstacle 2 type.
- dino_y  input  6  dino height above ground in pixels.
- dino_duck  input  1  dino is ducking.
- start_btn  input  1  start/restart button, level.
- game_state  output  2  0 = IDLE, 1 = RUN, 2 = OVER.
- obst_rst_n  output  1  registered; high only in RUN; drives obstacle generator rst_n.
- collision  output  1  one-clock pulse on the RUN->OVER transition.
- score  output  16  4 BCD digits, current score.
- hi_score  output  16  4 BCD digits, best score since reset.

Behaviour:
- Reset (async, rst_n low): game_state=IDLE, obst_rst_n=0, collision=0, score=0, hi_score=0, hit_q=0, prescaler=0, hold counter=0, start_q=0.
- Obstacle geometry per type:
  - type[2]=0 (cactus): width 8, height 10+4*type[1:0]; hit when dino_y < height.
  - types 4,5 (low bird): width 12; hit when dino_y < 16.
  - types 6,7 (high bird): width 12; hit when dino_duck=0 and dino_y < 24; never hit while ducking.
- X overlap: pos != 0 && pos <= DINO_X_MAX && pos+width-1 >= DINO_X_MIN. Compute pos+width in 10 bits; no wrap.
- hit_comb = overlap&vertical for obstacle 1 OR for obstacle 2.
- hit_q <= hit_comb every clock. Latency: inputs at edge N -> hit_q at N+1 -> state OVER at N+2.
- Start edge: start_q <= start_btn; start_rise = start_btn & ~start_q.
- FSM:
  - IDLE: start_rise -> RUN; score cleared, prescaler cleared.
  - RUN: hit_q -> OVER, collision=1 for exactly one clock. At that same edge, hi_score <= score if score > hi_score (BCD compare, MSD first).
  - OVER: hold counter counts to OVER_HOLD and saturates. start_rise with counter == OVER_HOLD -> RUN with score=0. Earlier presses are ignored, and are not queued.
  - Encoding 3 is illegal and goes to IDLE.
- hit_q is ignored in IDLE and OVER.
- obst_rst_n <= (next_state == RUN), so the obstacle generator is released on the same edge the state enters RUN.
- Score:
  - In RUN only, the prescaler counts 0..SCORE_DIV-1. On wrap, score increments by 1 in BCD; each digit 9 -> 0 with carry.
  - Score saturates at 9999.
  - The prescaler holds in IDLE/OVER.
  - The increment is suppressed on the RUN->OVER edge: the frozen score is the pre-collision value.
- Simultaneous events: a hit on both obstacles counts as a single collision. A start_rise in RUN is ignored.
- Reset mid-game: returns immediately to IDLE. hi_score is lost (reset value 0).

Test Plan:
- Reset, then start pulse with both obstacles at pos 0, 80 clocks: game_state=1 one clock after the start edge; obst_rst_n=1; score=0x0010; collision never asserted.
- RUN, obstacle1_pos=30, type=2 (cactus height 18), dino_y=5: hit_q next clock; game_state=2 two clocks after the inputs; collision high exactly 1 clock; hi_score=score; obst_rst_n=0.
- Same stimulus as the previous case but dino_y=18: no hit. Type 6 with dino_duck=1, dino_y=0: no hit. Type 6 with dino_duck=0, dino_y=0: hit.
- X boundaries, type 0 (width 8): pos=36 -> no hit; pos=35 -> hit; pos=13 (13+7=20) -> hit; pos=12 -> no hit; pos=0 with any type -> no hit.
- In OVER, press start at hold count 5: stays OVER. Press again after 16 clocks: RUN, score=0x0000, hi_score retained. Play to a lower score and collide: hi_score unchanged.
- Force a long RUN (SCORE_DIV=1, 10000+ clocks): score reaches 0x9999 and holds. Assert rst_n low mid-RUN: all outputs return to reset values immediately, without waiting for a clock edge.
